// File: rtl/jam_pkg.sv
// Shared sizing, FSM state encoding and permutation array type for the
// job-assignment permutation scheduler.
package jam_pkg;

   localparam int unsigned N  = 8;
   localparam int unsigned CW = 7;
   localparam int unsigned SW = 10;
   localparam int unsigned IW = $clog2(N);

   typedef logic [IW-1:0] idx_t;
   typedef idx_t [N-1:0]  perm_t;

   typedef enum logic [2:0] {IDLE, FETCH, DRAIN, OUT, NEXT, DONE} state_t;

   function automatic perm_t identity_perm();
      perm_t v;
      for (int unsigned m = 0; m < N; m++) v[idx_t'(m)] = idx_t'(m);
      return v;
   endfunction

endpackage

// File: rtl/jam_next_perm.sv
// Combinational next-lexicographic-permutation step; o_is_last flags a fully
// descending input (no successor exists).
module jam_next_perm
   import jam_pkg::*;
(
   input  perm_t i_p,
   output perm_t o_next_p,
   output logic  o_is_last
);

   idx_t  w_i;
   idx_t  w_j;
   logic  w_found;
   perm_t w_swp;

   always_comb begin
      w_found = 1'b0;
      w_i     = '0;
      w_j     = '0;
      for (int unsigned m = 0; m < N - 1; m++) begin
         if (i_p[idx_t'(m)] < i_p[idx_t'(m + 1)]) begin
            w_found = 1'b1;
            w_i     = idx_t'(m);
         end
      end
      for (int unsigned m = 0; m < N; m++) begin
         if ((idx_t'(m) > w_i) && (i_p[idx_t'(m)] > i_p[w_i])) w_j = idx_t'(m);
      end

      w_swp      = i_p;
      w_swp[w_i] = i_p[w_j];
      w_swp[w_j] = i_p[w_i];

      // Tail after the pivot is reversed: entry m takes entry N+i-m.
      o_next_p = w_swp;
      for (int unsigned m = 0; m < N; m++) begin
         if (idx_t'(m) > w_i)
            o_next_p[idx_t'(m)] = w_swp[idx_t'(N - 1 - m) + w_i + idx_t'(1)];
      end
      o_is_last = !w_found;
   end

endmodule

// File: rtl/jam_perm_ctrl.sv
// Permutation scheduler: walks all N! job assignments, sums ROM costs and
// hands each total downstream. Define JAM_PERM_IDX_EN to add the perm_idx port.
module jam_perm_ctrl
   import jam_pkg::*;
(
   input  logic          CLK,
   input  logic          RST_N,
   input  logic          start,
   output logic [IW-1:0] W,
   output logic [IW-1:0] J,
   input  logic [CW-1:0] Cost,
   output logic [SW-1:0] perm_sum,
   output logic          sum_valid,
   input  logic          sum_ready,
   output logic          busy,
   output logic          done
`ifdef JAM_PERM_IDX_EN
   ,
   output logic [15:0]   perm_idx
`endif
);

   state_t        r_state;
   state_t        w_state_nxt;
   perm_t         r_p;
   perm_t         w_next_p;
   logic          w_is_last;
   idx_t          r_k;
   idx_t          w_k_inc;
   logic          w_last_k;
   logic [SW-1:0] r_acc;
   logic [SW-1:0] w_acc_add;
   idx_t          r_w;
   idx_t          r_j;
   logic [SW-1:0] r_sum;
   logic          r_sum_valid;
   logic          r_busy;
   logic          r_done;
   logic          w_hs;

   jam_next_perm u_next_perm (
      .i_p       (r_p),
      .o_next_p  (w_next_p),
      .o_is_last (w_is_last)
   );

   assign w_hs      = r_sum_valid & sum_ready;
   assign w_k_inc   = r_k + idx_t'(1);
   assign w_last_k  = (r_k == idx_t'(N - 1));
   assign w_acc_add = r_acc + SW'(Cost);

   always_comb begin
      w_state_nxt = r_state;
      case (r_state)
         IDLE:    if (start) w_state_nxt = FETCH;
         FETCH:   if (w_last_k) w_state_nxt = DRAIN;
         DRAIN:   w_state_nxt = OUT;
         OUT:     if (w_hs) w_state_nxt = w_is_last ? DONE : NEXT;
         NEXT:    w_state_nxt = FETCH;
         DONE:    w_state_nxt = IDLE;
         default: w_state_nxt = IDLE;
      endcase
   end

   always_ff @(posedge CLK or negedge RST_N) begin
      if (!RST_N) r_state <= IDLE;
      else        r_state <= w_state_nxt;
   end

   // Cost arrives one cycle after its address, so FETCH adds the previous
   // address's cost and DRAIN picks up the final one.
   always_ff @(posedge CLK or negedge RST_N) begin
      if (!RST_N) begin
         r_p         <= identity_perm();
         r_k         <= '0;
         r_acc       <= '0;
         r_w         <= '0;
         r_j         <= '0;
         r_sum       <= '0;
         r_sum_valid <= 1'b0;
         r_busy      <= 1'b0;
         r_done      <= 1'b0;
      end else begin
         r_done <= 1'b0;
         case (r_state)
            IDLE: begin
               if (start) begin
                  r_p    <= identity_perm();
                  r_k    <= '0;
                  r_acc  <= '0;
                  r_w    <= '0;
                  r_j    <= '0;
                  r_busy <= 1'b1;
               end
            end
            FETCH: begin
               if (r_k != '0) r_acc <= w_acc_add;
               if (!w_last_k) begin
                  r_k <= w_k_inc;
                  r_w <= w_k_inc;
                  r_j <= r_p[w_k_inc];
               end
            end
            DRAIN: begin
               r_acc       <= w_acc_add;
               r_sum       <= w_acc_add;
               r_sum_valid <= 1'b1;
            end
            OUT: begin
               if (w_hs) begin
                  r_sum_valid <= 1'b0;
                  if (w_is_last) begin
                     r_busy <= 1'b0;
                     r_done <= 1'b1;
                  end
               end
            end
            NEXT: begin
               r_p   <= w_next_p;
               r_acc <= '0;
               r_k   <= '0;
               r_w   <= '0;
               r_j   <= w_next_p[0];
            end
            default: ;
         endcase
      end
   end

   assign W         = r_w;
   assign J         = r_j;
   assign perm_sum  = r_sum;
   assign sum_valid = r_sum_valid;
   assign busy      = r_busy;
   assign done      = r_done;

`ifdef JAM_PERM_IDX_EN
   logic [15:0] r_idx;

   always_ff @(posedge CLK or negedge RST_N) begin
      if (!RST_N)                          r_idx <= '0;
      else if ((r_state == IDLE) && start) r_idx <= '0;
      else if ((r_state == OUT) && w_hs)   r_idx <= r_idx + 16'd1;
   end

   assign perm_idx = r_idx;
`endif

endmodule
